// File: rtl/wm8731_cfg_seq.sv
// WM8731 register-configuration sequencer.
// Walks the codec register table and sends each 24-bit frame to the I2C
// serialiser, retrying NACKs and timeouts.
// Optional feature macro: WM8731_VOL_CTRL_EN. When it is defined, the headphone
// volume can be stepped in DONE and is rewritten with a 2-entry mini-sequence.
module wm8731_cfg_seq #(
   parameter logic [7:0] DEV_ADDR     = 8'h34,
   parameter int         NUM_REGS     = 11,
   parameter int         MAX_RETRY    = 3,
   parameter int         GAP_CYCLES   = 4,
   parameter int         XFER_TIMEOUT = 48
) (
   input  logic        clock_i2c,
   input  logic        reset,
   input  logic        cfg_go,
   input  logic        tr_end,
   input  logic        ack,
   input  logic        vol_up,
   input  logic        vol_down,
   output logic [23:0] i2c_data,
   output logic        start,
   output logic [3:0]  reg_index,
   output logic        busy,
   output logic        cfg_done,
   output logic        cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_XFER, S_CHECK, S_GAP, S_DONE, S_ERROR
   } state_t;

   localparam int CNT_MAX = (XFER_TIMEOUT > GAP_CYCLES) ? XFER_TIMEOUT : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = $clog2(MAX_RETRY + 2);

   localparam logic [CW-1:0] LOAD_LAST = CW'(1);
   localparam logic [CW-1:0] XFER_LAST = CW'(XFER_TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [3:0]    FULL_END  = 4'(NUM_REGS);
   localparam logic [3:0]    VOL_FIRST = 4'd3;
   localparam logic [3:0]    VOL_END   = 4'd5;
   localparam logic [6:0]    VOL_RESET = 7'h79;

   // Codec register word {reg[6:0], data[8:0]} for a table entry.
   function automatic logic [15:0] table_word(input logic [3:0] idx, input logic [6:0] vol);
      case (idx)
         4'd0:    table_word = 16'h1E00;
         4'd1:    table_word = 16'h0017;
         4'd2:    table_word = 16'h0217;
         4'd3:    table_word = {8'h04, 1'b0, vol};
         4'd4:    table_word = {8'h06, 1'b0, vol};
         4'd5:    table_word = 16'h0812;
         4'd6:    table_word = 16'h0A00;
         4'd7:    table_word = 16'h0C00;
         4'd8:    table_word = 16'h0E02;
         4'd9:    table_word = 16'h1000;
         4'd10:   table_word = 16'h1201;
         default: table_word = 16'h0000;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic            fail_q, fail_d;
   logic [3:0]      idx_q, idx_d;
   logic [3:0]      end_q, end_d;
   logic [23:0]     data_q, data_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [6:0]      vol_d;

`ifdef WM8731_VOL_CTRL_EN
   logic [6:0] vol_q;
   logic [7:0] vol_sum;
   logic [6:0] vol_new;
   logic       vol_change;

   // Clamped step of the headphone volume; simultaneous up/down is no request.
   assign vol_sum    = {1'b0, vol_q} + 8'd4;
   assign vol_new    = vol_up ? ((vol_sum > 8'h7F) ? 7'h7F : vol_sum[6:0])
                              : ((vol_q < 7'h34) ? 7'h30 : vol_q - 7'd4);
   assign vol_change = (vol_up ^ vol_down) && (vol_new != vol_q);
`else
   logic unused_vol;
   assign unused_vol = vol_up | vol_down;
   assign vol_d      = VOL_RESET;
`endif

   // State register and datapath registers, all with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clock_i2c) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
         fail_q  <= 1'b0;
         idx_q   <= '0;
         end_q   <= FULL_END;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef WM8731_VOL_CTRL_EN
         vol_q   <= VOL_RESET;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         fail_q  <= fail_d;
         idx_q   <= idx_d;
         end_q   <= end_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef WM8731_VOL_CTRL_EN
         vol_q   <= vol_d;
`endif
      end
   end

   // Next-state logic for the sequencer FSM and its counters.
   // NOTE: every signal gets a default first so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      fail_d  = fail_q;
      idx_d   = idx_q;
      end_d   = end_q;
      data_d  = data_q;
      done_d  = done_q;
      err_d   = err_q;
`ifdef WM8731_VOL_CTRL_EN
      vol_d   = vol_q;
`endif
      case (state_q)
         S_IDLE: begin
            idx_d   = '0;
            retry_d = '0;
            end_d   = FULL_END;
            cnt_d   = '0;
            data_d  = {DEV_ADDR, table_word(4'd0, vol_d)};
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (cnt_q == LOAD_LAST) begin
               cnt_d   = '0;
               state_d = S_XFER;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_XFER: begin
            if (tr_end) begin
               fail_d  = ack;
               cnt_d   = '0;
               state_d = S_CHECK;
            end else if (cnt_q == XFER_LAST) begin
               fail_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (!fail_q) begin
               retry_d = '0;
               idx_d   = idx_q + 4'd1;
               state_d = S_GAP;
            end else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 1'b1;
               state_d = S_GAP;
            end else begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (idx_q == end_q) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  data_d  = {DEV_ADDR, table_word(idx_q, vol_d)};
                  state_d = S_LOAD;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (cfg_go) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
`ifdef WM8731_VOL_CTRL_EN
            else if (vol_change) begin
               vol_d   = vol_new;
               idx_d   = VOL_FIRST;
               end_d   = VOL_END;
               retry_d = '0;
               cnt_d   = '0;
               data_d  = {DEV_ADDR, table_word(VOL_FIRST, vol_new)};
               state_d = S_LOAD;
            end
`endif
         end
         S_ERROR: begin
            if (cfg_go) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign start     = (state_q == S_XFER) || (state_q == S_CHECK);
   assign busy      = (state_q == S_LOAD) || (state_q == S_XFER) ||
                      (state_q == S_CHECK) || (state_q == S_GAP);
   assign i2c_data  = data_q;
   assign reg_index = idx_q;
   assign cfg_done  = done_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Directed testbench for wm8731_cfg_seq with a behavioural serialiser model.
// Define WM8731_VOL_CTRL_EN for both files to exercise the volume feature.
module tb_wm8731_cfg_seq;

   logic        clock_i2c = 1'b0;
   logic        reset     = 1'b1;
   logic        cfg_go    = 1'b0;
   logic        tr_end    = 1'b0;
   logic        ack       = 1'b1;
   logic        vol_up    = 1'b0;
   logic        vol_down  = 1'b0;
   logic [23:0] i2c_data;
   logic        start;
   logic [3:0]  reg_index;
   logic        busy;
   logic        cfg_done;
   logic        cfg_err;

   wm8731_cfg_seq dut (
      .clock_i2c (clock_i2c),
      .reset     (reset),
      .cfg_go    (cfg_go),
      .tr_end    (tr_end),
      .ack       (ack),
      .vol_up    (vol_up),
      .vol_down  (vol_down),
      .i2c_data  (i2c_data),
      .start     (start),
      .reg_index (reg_index),
      .busy      (busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err)
   );

   initial forever #5 clock_i2c = ~clock_i2c;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [23:0] frames[$];
   int          high_q[$];
   int          min_gap = 1000;
   int          nack_left[16];
   int          hang_left[16];
   int          xcnt = 0;
   int          lowc = 0;
   int          highc = 0;
   bit          prev_start = 1'b0;
   bit          hang = 1'b0;

   localparam logic [23:0] EXP_FRAMES [11] = '{
      24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
      24'h340A00, 24'h340C00, 24'h340E02, 24'h341000, 24'h341201
   };

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Serialiser model: logs frames, answers 33 clocks after start rises,
   // and injects a stray tr_end during every low period.
   initial begin
      forever begin
         @(negedge clock_i2c);
         tr_end = 1'b0;
         ack    = 1'b1;
         if (start) begin
            if (!prev_start) begin
               if (frames.size() > 0 && lowc < min_gap) min_gap = lowc;
               frames.push_back(i2c_data);
               lowc  = 0;
               xcnt  = 0;
               highc = 0;
               hang  = hang_left[reg_index] > 0;
               if (hang) hang_left[reg_index]--;
            end
            xcnt++;
            highc++;
            if (xcnt == 33 && !hang) begin
               tr_end = 1'b1;
               ack    = 1'b0;
               if (nack_left[reg_index] > 0) begin
                  ack = 1'b1;
                  nack_left[reg_index]--;
               end
            end
         end else begin
            if (prev_start) high_q.push_back(highc);
            lowc++;
            if (lowc == 2) begin
               tr_end = 1'b1;
               ack    = 1'b0;
            end
         end
         prev_start = start;
      end
   end

   task automatic clear_log();
      frames.delete();
      high_q.delete();
      min_gap = 1000;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock_i2c);
      clear_log();
      for (int i = 0; i < 16; i++) begin
         nack_left[i] = 0;
         hang_left[i] = 0;
      end
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clock_i2c);
         n++;
      end while (!((cfg_done || cfg_err) && !busy) && n < budget);
      check(tag, 32'((cfg_done || cfg_err) && !busy), 1);
   endtask

   task automatic wait_start(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clock_i2c);
         n++;
      end while (!start && n < budget);
      check(tag, 32'(start), 1);
   endtask

   task automatic pulse_go();
      cfg_go = 1'b1;
      @(negedge clock_i2c);
      cfg_go = 1'b0;
   endtask

   int n_entry5;

   initial begin
      // Reset state and automatic start
      apply_reset();
      check("rst_start", 32'(start), 0);
      check("rst_data", 32'(i2c_data), 0);
      check("rst_index", 32'(reg_index), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(cfg_done), 0);
      check("rst_err", 32'(cfg_err), 0);
      reset = 1'b0;
      @(negedge clock_i2c);
      check("auto_busy", 32'(busy), 1);
      check("auto_start_low", 32'(start), 0);
      check("auto_first_frame", 32'(i2c_data), 32'h341E00);

      // Full sequence, all ACKed; cfg_go mid-run must be ignored
      repeat (100) @(negedge clock_i2c);
      pulse_go();
      wait_end("t1_end", 3000);
      check("t1_nframes", 32'(frames.size()), 11);
      for (int i = 0; i < 11 && i < frames.size(); i++)
         check($sformatf("t1_frame%0d", i), 32'(frames[i]), 32'(EXP_FRAMES[i]));
      check("t1_min_gap_ge6", 32'(min_gap >= 6), 1);
      check("t1_xfer_len", 32'(high_q.size() > 0 ? high_q[0] : 0), 34);
      check("t1_done", 32'(cfg_done), 1);
      check("t1_busy", 32'(busy), 0);
      check("t1_err", 32'(cfg_err), 0);
      check("t1_start", 32'(start), 0);

`ifndef WM8731_VOL_CTRL_EN
      // Volume inputs have no effect in the default build
      vol_up = 1'b1;
      @(negedge clock_i2c);
      vol_up = 1'b0;
      repeat (3) @(negedge clock_i2c);
      check("novol_busy", 32'(busy), 0);
      check("novol_nframes", 32'(frames.size()), 11);
`endif

      // Entry 5 NACKed twice, then ACKed
      apply_reset();
      nack_left[5] = 2;
      reset = 1'b0;
      wait_end("t2_end", 3000);
      n_entry5 = 0;
      foreach (frames[i]) if (frames[i] == 24'h340812) n_entry5++;
      check("t2_nframes", 32'(frames.size()), 13);
      check("t2_entry5_sends", 32'(n_entry5), 3);
      check("t2_done", 32'(cfg_done), 1);
      check("t2_err", 32'(cfg_err), 0);
      check("t2_min_gap_ge6", 32'(min_gap >= 6), 1);

      // Entry 2 always NACKed
      apply_reset();
      nack_left[2] = 100;
      reset = 1'b0;
      wait_end("t3_end", 3000);
      check("t3_err", 32'(cfg_err), 1);
      check("t3_done", 32'(cfg_done), 0);
      check("t3_index", 32'(reg_index), 2);
      check("t3_start", 32'(start), 0);
      check("t3_nframes", 32'(frames.size()), 6);
      check("t3_last_frame", 32'(frames.size() > 0 ? frames[frames.size()-1] : 0), 32'h340217);
      repeat (200) @(negedge clock_i2c);
      check("t3_no_more_frames", 32'(frames.size()), 6);

      // Entry 0 never answered -> timeouts, then recovery by cfg_go
      apply_reset();
      hang_left[0] = 100;
      reset = 1'b0;
      wait_end("t4_end", 3000);
      check("t4_err", 32'(cfg_err), 1);
      check("t4_index", 32'(reg_index), 0);
      check("t4_nframes", 32'(frames.size()), 4);
      check("t4_frame_last", 32'(frames.size() > 3 ? frames[3] : 0), 32'h341E00);
      check("t4_timeout_len", 32'(high_q.size() > 0 ? high_q[0] : 0), 49);
      hang_left[0] = 0;
      clear_log();
      pulse_go();
      check("t4_go_clears_err", 32'(cfg_err), 0);
      wait_end("t4_rerun_end", 3000);
      check("t4_rerun_done", 32'(cfg_done), 1);
      check("t4_rerun_nframes", 32'(frames.size()), 11);

      // Reset during clock 15 of the first transfer
      apply_reset();
      reset = 1'b0;
      wait_start("t5_start_seen", 20);
      repeat (14) @(negedge clock_i2c);
      check("t5_start_before", 32'(start), 1);
      reset = 1'b1;
      @(negedge clock_i2c);
      check("t5_start_dropped", 32'(start), 0);
      check("t5_data", 32'(i2c_data), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_index", 32'(reg_index), 0);
      @(negedge clock_i2c);
      clear_log();
      reset = 1'b0;
      wait_end("t5_end", 3000);
      check("t5_first_frame", 32'(frames.size() > 0 ? frames[0] : 0), 32'h341E00);
      check("t5_nframes", 32'(frames.size()), 11);
      check("t5_done", 32'(cfg_done), 1);

`ifdef WM8731_VOL_CTRL_EN
      // Volume steps in DONE
      clear_log();
      vol_up = 1'b1;
      @(negedge clock_i2c);
      vol_up = 1'b0;
      check("v1_busy", 32'(busy), 1);
      check("v1_done_kept", 32'(cfg_done), 1);
      wait_end("v1_end", 1000);
      check("v1_nframes", 32'(frames.size()), 2);
      check("v1_r2", 32'(frames.size() > 0 ? frames[0] : 0), 32'h34047D);
      check("v1_r3", 32'(frames.size() > 1 ? frames[1] : 0), 32'h34067D);
      check("v1_done", 32'(cfg_done), 1);
      clear_log();
      vol_up = 1'b1;
      @(negedge clock_i2c);
      vol_up = 1'b0;
      wait_end("v2_end", 1000);
      check("v2_nframes", 32'(frames.size()), 2);
      check("v2_r2", 32'(frames.size() > 0 ? frames[0] : 0), 32'h34047F);
      check("v2_r3", 32'(frames.size() > 1 ? frames[1] : 0), 32'h34067F);
      check("v2_done", 32'(cfg_done), 1);
      // At the ceiling, and with both pulses together, nothing is sent
      clear_log();
      vol_up = 1'b1;
      @(negedge clock_i2c);
      vol_up = 1'b0;
      check("v3_clamped_idle", 32'(busy), 0);
      vol_up   = 1'b1;
      vol_down = 1'b1;
      @(negedge clock_i2c);
      vol_up   = 1'b0;
      vol_down = 1'b0;
      repeat (3) @(negedge clock_i2c);
      check("v4_both_idle", 32'(busy), 0);
      check("v4_nframes", 32'(frames.size()), 0);
      vol_down = 1'b1;
      @(negedge clock_i2c);
      vol_down = 1'b0;
      wait_end("v5_end", 1000);
      check("v5_r2", 32'(frames.size() > 0 ? frames[0] : 0), 32'h34047B);
      check("v5_r3", 32'(frames.size() > 1 ? frames[1] : 0), 32'h34067B);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
